hwag_cmp_scheduler: RTL and testbench

Time-multiplexed compare scheduler sharing a single magnitude comparator between CH_NUM angle-event channels. Each channel is armed with a compare angle. The scheduler scans armed channels round-robin against the live angle counter and emits a one-cycle hit pulse when a channel's angle is reached. It sits between the angle counter and the ignition/injection output logic and replaces per-channel comparators.

---
 rtl/hwag_cmp_sched_pkg.sv | 21 ++
 rtl/comparator.sv | 14 +
 rtl/hwag_cmp_scheduler.sv | 122 ++++++++++++
 tb/tb_hwag_cmp_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_cmp_sched_pkg.sv
// Shared types and helpers for the hwag compare scheduler.
package hwag_cmp_sched_pkg;

    localparam int SCHED_CH_NUM = 4;
    localparam int SCHED_WIDTH  = 24;

    // Width of a channel index; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int SCHED_PTR_W = ptr_w(SCHED_CH_NUM);

    typedef struct packed {
        logic                   valid;
        logic [SCHED_PTR_W-1:0] ch;
        logic [SCHED_WIDTH-1:0] cmp;
        logic [SCHED_WIDTH-1:0] angle;
    } stage_t;

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator shared by all scheduler channels.
module comparator #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ageb,
    output logic             alb
);

    assign alb  = (a < b);
    assign ageb = ~alb;

endmodule

// File: rtl/hwag_cmp_scheduler.sv
// Round-robin compare scheduler: one comparator shared by CH_NUM angle channels.
// Optional HWAG_CMP_SCHED_WRAP_EN: channels armed behind the angle wait for the next revolution.
module hwag_cmp_scheduler
    import hwag_cmp_sched_pkg::*;
#(
    parameter int CH_NUM = SCHED_CH_NUM,
    parameter int WIDTH  = SCHED_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           angle,
    input  logic [CH_NUM*WIDTH-1:0]    ch_cmp,
    input  logic [CH_NUM-1:0]          ch_arm,
    input  logic [CH_NUM-1:0]          ch_disarm,
    output logic [CH_NUM-1:0]          ch_armed,
    output logic [CH_NUM-1:0]          ch_hit,
    output logic [ptr_w(CH_NUM)-1:0]   scan_ptr
);

    localparam int PTR_W = ptr_w(CH_NUM);

    logic [WIDTH-1:0]  cmp_reg [CH_NUM];
    logic [CH_NUM-1:0] armed_reg;
    logic [CH_NUM-1:0] hit_reg;
    logic [PTR_W-1:0]  ptr_reg;
    stage_t            s0_reg;

    logic [CH_NUM-1:0] touch;
    logic [CH_NUM-1:0] s0_sel;
    logic [CH_NUM-1:0] primed;
    logic              ageb;
    logic              alb;
    logic              s0_live;
    logic              s0_hit;

    // Any arm or disarm kills whatever the pipeline holds for that channel.
    assign touch = ch_arm | ch_disarm;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_sel
            assign s0_sel[gi] = (s0_reg.ch == PTR_W'(gi));
        end
    endgenerate

    comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a    (s0_reg.angle),
        .b    (s0_reg.cmp),
        .ageb (ageb),
        .alb  (alb)
    );

    assign s0_live = s0_reg.valid & en & (|(s0_sel & armed_reg & ~touch));
    assign s0_hit  = s0_live & (|(s0_sel & primed)) & ageb;

`ifdef HWAG_CMP_SCHED_WRAP_EN
    logic [CH_NUM-1:0] primed_reg;

    // A channel armed behind the angle becomes primed once a scan sees the angle below it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_reg <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (ch_arm[i] && !ch_disarm[i]) begin
                    primed_reg[i] <= (angle < ch_cmp[i*WIDTH +: WIDTH]);
                end else if (s0_live && s0_sel[i] && !primed_reg[i] && alb) begin
                    primed_reg[i] <= 1'b1;
                end
            end
        end
    end

    assign primed = primed_reg;
`else
    logic alb_unused;
    assign alb_unused = alb;
    assign primed     = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            s0_reg    <= '0;
            armed_reg <= '0;
            hit_reg   <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                cmp_reg[i] <= '0;
            end
        end else begin
            hit_reg <= s0_hit ? s0_sel : '0;

            if (en) begin
                ptr_reg <= (ptr_reg == PTR_W'(CH_NUM - 1)) ? '0 : ptr_reg + 1'b1;
            end

            s0_reg.valid <= en & armed_reg[ptr_reg] & ~touch[ptr_reg];
            s0_reg.ch    <= ptr_reg;
            s0_reg.cmp   <= cmp_reg[ptr_reg];
            s0_reg.angle <= angle;

            // Disarm beats arm; a fresh arm beats a hit decided in the same cycle.
            for (int i = 0; i < CH_NUM; i++) begin
                if (ch_disarm[i]) begin
                    armed_reg[i] <= 1'b0;
                end else if (ch_arm[i]) begin
                    armed_reg[i] <= 1'b1;
                    cmp_reg[i]   <= ch_cmp[i*WIDTH +: WIDTH];
                end else if (s0_hit && s0_sel[i]) begin
                    armed_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign ch_armed = armed_reg;
    assign ch_hit   = hit_reg;
    assign scan_ptr = ptr_reg;

endmodule

// File: tb/tb_hwag_cmp_scheduler.sv
// Randomised and directed bench for hwag_cmp_scheduler against a visit-log reference model.
module tb_hwag_cmp_scheduler;

    localparam int CH_NUM = 4;
    localparam int WIDTH  = 24;
    localparam int PW     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic [WIDTH-1:0]        angle;
    logic [CH_NUM*WIDTH-1:0] ch_cmp;
    logic [CH_NUM-1:0]       ch_arm;
    logic [CH_NUM-1:0]       ch_disarm;
    logic [CH_NUM-1:0]       ch_armed;
    logic [CH_NUM-1:0]       ch_hit;
    logic [PW-1:0]           scan_ptr;

    always #5 clk = ~clk;

    hwag_cmp_scheduler #(
        .CH_NUM (CH_NUM),
        .WIDTH  (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .angle     (angle),
        .ch_cmp    (ch_cmp),
        .ch_arm    (ch_arm),
        .ch_disarm (ch_disarm),
        .ch_armed  (ch_armed),
        .ch_hit    (ch_hit),
        .scan_ptr  (scan_ptr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each enabled cycle logs a visit of the channel under the pointer;
    // the visit resolves one cycle later unless the channel was touched meanwhile.
    typedef struct {
        int          t;
        int          ch;
        int unsigned ang;
    } visit_t;

    visit_t            visits[$];
    int unsigned       m_cmp[CH_NUM];
    bit                m_armed[CH_NUM];
    bit                m_primed[CH_NUM];
    int                last_touch[CH_NUM];
    int                m_ptr;
    logic [CH_NUM-1:0] exp_hit;
    int unsigned       m_hit_ang;

    int hits_seen;
    int last_hit_ch;
    int last_hit_cyc;

    function automatic logic [CH_NUM-1:0] m_armed_vec();
        logic [CH_NUM-1:0] v;
        for (int i = 0; i < CH_NUM; i++) v[i] = m_armed[i];
        return v;
    endfunction

    function automatic void model_reset();
        visits.delete();
        for (int i = 0; i < CH_NUM; i++) begin
            m_cmp[i]      = 0;
            m_armed[i]    = 1'b0;
            m_primed[i]   = 1'b0;
            last_touch[i] = -100;
        end
        m_ptr   = 0;
        exp_hit = '0;
    endfunction

    function automatic void model_step();
        visit_t      v;
        int unsigned slice;
        exp_hit = '0;
        while (visits.size() > 0 && visits[0].t < cyc - 1) void'(visits.pop_front());
        if (visits.size() > 0 && visits[0].t == cyc - 1) begin
            v = visits.pop_front();
            if (en && m_armed[v.ch] && last_touch[v.ch] < v.t && !ch_arm[v.ch] && !ch_disarm[v.ch]) begin
                if (m_primed[v.ch] && v.ang >= m_cmp[v.ch]) begin
                    exp_hit[v.ch] = 1'b1;
                    m_armed[v.ch] = 1'b0;
                    m_hit_ang     = v.ang;
                end else if (!m_primed[v.ch] && v.ang < m_cmp[v.ch]) begin
                    m_primed[v.ch] = 1'b1;
                end
            end
        end
        if (en) visits.push_back('{cyc, m_ptr, int'(angle)});
        for (int i = 0; i < CH_NUM; i++) begin
            slice = int'(ch_cmp[i*WIDTH +: WIDTH]);
            if (ch_arm[i] || ch_disarm[i]) last_touch[i] = cyc;
            if (ch_disarm[i]) begin
                m_armed[i] = 1'b0;
            end else if (ch_arm[i]) begin
                m_armed[i] = 1'b1;
                m_cmp[i]   = slice;
`ifdef HWAG_CMP_SCHED_WRAP_EN
                m_primed[i] = (int'(angle) < slice);
`else
                m_primed[i] = 1'b1;
`endif
            end
        end
        if (en) m_ptr = (m_ptr + 1) % CH_NUM;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("hit", ch_hit, exp_hit);
        check("armed", ch_armed, m_armed_vec());
        check("ptr", scan_ptr, m_ptr);
        check("onehot", ($countones(ch_hit) <= 1), 1);
        if (ch_hit != '0) begin
            hits_seen++;
            for (int i = 0; i < CH_NUM; i++) if (ch_hit[i]) last_hit_ch = i;
            last_hit_cyc = cyc;
        end
        cyc++;
        ch_arm    = '0;
        ch_disarm = '0;
    endtask

    task automatic set_cmp(input int ch, input int unsigned val);
        ch_cmp[ch*WIDTH +: WIDTH] = val[WIDTH-1:0];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        ch_arm    = '0;
        ch_disarm = '0;
        @(posedge clk);
        #1;
        check("rst_hit", ch_hit, 0);
        check("rst_armed", ch_armed, 0);
        check("rst_ptr", scan_ptr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hits_seen = 0;
    endtask

    int t_mark;
    int order[$];

    initial begin
        rst = 1'b1; en = 1'b0; angle = '0; ch_cmp = '0; ch_arm = '0; ch_disarm = '0;
        hits_seen = 0; last_hit_ch = -1; last_hit_cyc = -1; m_hit_ang = 0;
        model_reset();
        #1;
        do_reset();

        // Ramp to a single channel's compare angle.
        en = 1'b1; angle = 0; set_cmp(2, 1000); ch_arm[2] = 1'b1;
        step();
        t_mark = -1;
        for (int k = 1; k < 1020; k++) begin
            angle = k;
            if (k == 1000) t_mark = cyc;
            step();
        end
        check("ramp_hit_count", hits_seen, 1);
        check("ramp_hit_ch", last_hit_ch, 2);
        check("ramp_latency_ok", (last_hit_cyc + 1 - t_mark >= 2) && (last_hit_cyc + 1 - t_mark <= 6), 1);

`ifndef HWAG_CMP_SCHED_WRAP_EN
        // Four channels already passed: hits follow pointer order on consecutive cycles.
        do_reset();
        en = 1'b1; angle = 600;
        for (int k = 0; k < 8 && scan_ptr != 2'd3; k++) step();
        set_cmp(0, 100); set_cmp(1, 100); set_cmp(2, 101); set_cmp(3, 500);
        ch_arm = '1;
        step();
        order.delete();
        for (int k = 0; k < 10; k++) begin
            step();
            if (ch_hit != '0) order.push_back(last_hit_ch);
        end
        check("burst_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) check("burst_order", order[i], i);
`else
        // Armed behind the angle: waits for the wrap, then fires near the compare value.
        do_reset();
        en = 1'b1; angle = 200; set_cmp(1, 100); ch_arm[1] = 1'b1;
        step();
        for (int k = 0; k < 20; k++) step();
        check("wrap_no_early_hit", hits_seen, 0);
        for (int k = 0; k < 150; k++) begin
            angle = k;
            step();
        end
        check("wrap_hit_count", hits_seen, 1);
        check("wrap_hit_ang_ok", (m_hit_ang >= 100 && m_hit_ang <= 103), 1);
`endif

        // Re-arm in the cycle the pending hit would be decided.
        do_reset();
        en = 1'b1; angle = 60;
        for (int k = 0; k < 8 && scan_ptr != 2'd0; k++) step();
        set_cmp(3, 50); ch_arm[3] = 1'b1;
        step();
        for (int k = 0; k < 8 && scan_ptr != 2'd3; k++) step();
        step();
        set_cmp(3, 5000); ch_arm[3] = 1'b1;
        step();
        check("rearm_suppress", ch_hit, 0);
        for (int k = 1; k <= 40; k++) begin
            angle = 60 + 200 * k;
            step();
        end
        check("rearm_hit_count", hits_seen, 1);
        check("rearm_hit_ang_ok", (m_hit_ang >= 5000), 1);

        // Same-cycle arm and disarm: disarm wins.
        do_reset();
        en = 1'b1; angle = 500; set_cmp(1, 100); ch_arm[1] = 1'b1; ch_disarm[1] = 1'b1;
        step();
        check("armdis_armed", ch_armed[1], 0);
        for (int k = 0; k < 10; k++) step();
        check("armdis_no_hit", hits_seen, 0);

        // Scan disabled: no hit until en returns.
        en = 1'b0; angle = 5; set_cmp(0, 10); ch_arm[0] = 1'b1;
        step();
        angle = 500;
        for (int k = 0; k < 10; k++) step();
        check("en_off_no_hit", hits_seen, 0);
        en = 1'b1;
        t_mark = cyc;
        for (int k = 0; k < 8 && hits_seen == 0; k++) step();
        check("en_on_hit", hits_seen, 1);
        check("en_on_latency_ok", (last_hit_cyc + 1 - t_mark <= 6), 1);

        // Asynchronous reset in the middle of a scan.
        do_reset();
        en = 1'b1; angle = 5; set_cmp(0, 10); ch_arm[0] = 1'b1;
        step();
        angle = 500;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hit", ch_hit, 0);
        check("async_rst_armed", ch_armed, 0);
        check("async_rst_ptr", scan_ptr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hits_seen = 0;
        for (int k = 0; k < 12; k++) step();
        check("post_rst_no_hit", hits_seen, 0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            angle = (int'(angle) + $urandom_range(0, 30)) % 3000;
            for (int i = 0; i < CH_NUM; i++) begin
                set_cmp(i, $urandom_range(0, 2999));
                ch_arm[i]    = ($urandom_range(0, 7) == 0);
                ch_disarm[i] = ($urandom_range(0, 15) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
